id_ex_pipe: RTL and testbench

Parametrised ID→EX pipeline stage with a full valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating back-pressure counter. It sits between the decode stage and the execute stage. It carries the decoded op fields and operands, and adds stall and flush support so that EX, MEM or a branch unit can back-pressure or kill the front end without losing or duplicating instructions. Empty slots are presented to EX as all-zero bubbles, the NOP encoding.

---
 rtl/id_ex_pipe.sv | 155 +++++++++++++++
 tb/tb_id_ex_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register: valid/ready handshake, two-entry skid buffer,
// synchronous flush, and a saturating count of back-pressured cycles.
module id_ex_pipe #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid,
    output logic             id_ready,
    input  logic [6:0]       id_t,
    input  logic [2:0]       id_st,
    input  logic             id_sst,
    input  logic [XLEN-1:0]  id_n1,
    input  logic [XLEN-1:0]  id_n2,
    input  logic [RA_W-1:0]  id_wa,
    input  logic             id_we,

    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [6:0]       ex_t,
    output logic [2:0]       ex_st,
    output logic             ex_sst,
    output logic [XLEN-1:0]  ex_n1,
    output logic [XLEN-1:0]  ex_n2,
    output logic [RA_W-1:0]  ex_wa,
    output logic             ex_we,

    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             clr_cnt
);

    typedef struct packed {
        logic [6:0]      t;
        logic [2:0]      st;
        logic            sst;
        logic [XLEN-1:0] n1;
        logic [XLEN-1:0] n2;
        logic [RA_W-1:0] wa;
        logic            we;
    } beat_t;

    // Encoding is {skid_valid, main_valid}, so bit 1 is the skid-full flop.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    beat_t            main_q, main_d;
    beat_t            skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    beat_t            in_beat;
    logic             main_valid;
    logic             accept;
    logic             retire;

    assign in_beat    = '{t: id_t, st: id_st, sst: id_sst, n1: id_n1,
                          n2: id_n2, wa: id_wa, we: id_we};
    assign main_valid = state_q[0];
    assign accept     = id_valid & ~state_q[1];
    assign retire     = main_valid & ex_ready;

    // NOTE: payload registers are reset as well so a bubble is all-zero
    // from the very first cycle, not just once a beat has passed through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default on every target keeps this block latch-free.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_beat;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        main_d = in_beat;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_beat;
                    end else if (retire) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                TWO: begin
                    if (retire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Counter is independent of flush; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (main_valid && !ex_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // All outputs come straight from flops; ex_ready never reaches id_ready.
    always_comb begin
        id_ready  = ~state_q[1];
        ex_valid  = main_valid;
        ex_t      = main_q.t;
        ex_st     = main_q.st;
        ex_sst    = main_q.sst;
        ex_n1     = main_q.n1;
        ex_n2     = main_q.n2;
        ex_wa     = main_q.wa;
        ex_we     = main_q.we;
        stall_cnt = cnt_q;
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed vector table, hand-written
// corner sequences, and a queue-based reference model under random traffic.
module tb_id_ex_pipe;

    localparam int XLEN    = 32;
    localparam int RA_W    = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [6:0]      t;
        logic [2:0]      st;
        logic            sst;
        logic [XLEN-1:0] n1;
        logic [XLEN-1:0] n2;
        logic [RA_W-1:0] wa;
        logic            we;
    } beat_t;

    typedef struct {
        logic            id_valid;
        logic [XLEN-1:0] n1;
        logic [RA_W-1:0] wa;
        logic            ex_ready;
        logic            exp_valid;
        logic [XLEN-1:0] exp_n1;
        logic [RA_W-1:0] exp_wa;
        logic            exp_ready;
        int              exp_cnt;
    } vec_t;

    logic             clk, rst;
    logic             id_valid, id_ready;
    logic [6:0]       id_t;
    logic [2:0]       id_st;
    logic             id_sst;
    logic [XLEN-1:0]  id_n1, id_n2;
    logic [RA_W-1:0]  id_wa;
    logic             id_we;
    logic             ex_valid, ex_ready;
    logic [6:0]       ex_t;
    logic [2:0]       ex_st;
    logic             ex_sst;
    logic [XLEN-1:0]  ex_n1, ex_n2;
    logic [RA_W-1:0]  ex_wa;
    logic             ex_we;
    logic             flush, clr_cnt;
    logic [CNT_W-1:0] stall_cnt;
    beat_t            ex_beat;

    int n_cmp  = 0;
    int n_fail = 0;

    id_ex_pipe #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_t(id_t), .id_st(id_st), .id_sst(id_sst),
        .id_n1(id_n1), .id_n2(id_n2), .id_wa(id_wa), .id_we(id_we),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_t(ex_t), .ex_st(ex_st), .ex_sst(ex_sst),
        .ex_n1(ex_n1), .ex_n2(ex_n2), .ex_wa(ex_wa), .ex_we(ex_we),
        .flush(flush), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
    );

    assign ex_beat = {ex_t, ex_st, ex_sst, ex_n1, ex_n2, ex_wa, ex_we};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input beat_t b, input logic exr,
                         input logic fl, input logic clr);
        id_valid = v;
        {id_t, id_st, id_sst, id_n1, id_n2, id_wa, id_we} = b;
        ex_ready = exr;
        flush    = fl;
        clr_cnt  = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input logic [XLEN-1:0] n1, input logic [RA_W-1:0] wa);
        beat_t b;
        b    = '0;
        b.t  = 7'h33;
        b.st = 3'd5;
        b.sst = 1'b1;
        b.n1 = n1;
        b.n2 = ~n1;
        b.wa = wa;
        b.we = 1'b1;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.t   = 7'($urandom);
        b.st  = 3'($urandom);
        b.sst = 1'($urandom);
        b.n1  = $urandom;
        b.n2  = $urandom;
        b.wa  = RA_W'($urandom);
        b.we  = 1'($urandom);
        return b;
    endfunction

    vec_t  vecs[16];
    beat_t idle;
    beat_t model_q[$];
    int    model_cnt;

    initial begin
        idle = '0;
        rst  = 1'b1;
        drive(1'b0, idle, 1'b0, 1'b0, 1'b0);

        // Streaming: 8 back-to-back beats then drain, ex_ready held high.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, XLEN'(i + 1), 5'd1, 1'b1, 1'b1, XLEN'(i + 1), 5'd1, 1'b1, 0};
        vecs[8]  = '{1'b0, 0,     5'd0, 1'b1, 1'b0, 0,     5'd0, 1'b1, 0};
        // Skid fill: A accepted, B absorbed by skid, C held off until drain.
        vecs[9]  = '{1'b1, 'hA, 5'd3, 1'b1, 1'b1, 'hA, 5'd3, 1'b1, 0};
        vecs[10] = '{1'b1, 'hB, 5'd4, 1'b0, 1'b1, 'hA, 5'd3, 1'b0, 1};
        vecs[11] = '{1'b1, 'hC, 5'd5, 1'b0, 1'b1, 'hA, 5'd3, 1'b0, 2};
        vecs[12] = '{1'b1, 'hC, 5'd5, 1'b0, 1'b1, 'hA, 5'd3, 1'b0, 3};
        vecs[13] = '{1'b1, 'hC, 5'd5, 1'b1, 1'b1, 'hB, 5'd4, 1'b1, 3};
        vecs[14] = '{1'b1, 'hC, 5'd5, 1'b1, 1'b1, 'hC, 5'd5, 1'b1, 3};
        vecs[15] = '{1'b0, 0,     5'd0, 1'b1, 1'b0, 0,     5'd0, 1'b1, 3};

        tick();
        check("reset_ex_valid", 96'(ex_valid), 96'(0));
        check("reset_payload", 96'(ex_beat), 96'(0));
        check("reset_id_ready", 96'(id_ready), 96'(1));
        check("reset_cnt", 96'(stall_cnt), 96'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].id_valid, mk(vecs[i].n1, vecs[i].wa), vecs[i].ex_ready, 1'b0, 1'b0);
            if (!vecs[i].id_valid) id_we = 1'b0;
            tick();
            check($sformatf("vec%0d_ex_valid", i), 96'(ex_valid), 96'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ex_n1", i), 96'(ex_n1), 96'(vecs[i].exp_n1));
            check($sformatf("vec%0d_ex_wa", i), 96'(ex_wa), 96'(vecs[i].exp_wa));
            check($sformatf("vec%0d_id_ready", i), 96'(id_ready), 96'(vecs[i].exp_ready));
            check($sformatf("vec%0d_cnt", i), 96'(stall_cnt), 96'(vecs[i].exp_cnt));
        end

        // Flush in TWO with a beat offered; counter keeps counting the stall.
        drive(1'b1, mk('h11, 5'd1), 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, mk('h12, 5'd2), 1'b0, 1'b0, 1'b0);
        tick();
        check("two_id_ready", 96'(id_ready), 96'(0));
        drive(1'b1, mk('hDD, 5'd9), 1'b0, 1'b1, 1'b0);
        tick();
        check("flush_two_valid", 96'(ex_valid), 96'(0));
        check("flush_two_payload", 96'(ex_beat), 96'(0));
        check("flush_two_id_ready", 96'(id_ready), 96'(1));
        check("flush_two_cnt", 96'(stall_cnt), 96'(2));
        // Flush in ONE with accept+retire: the new beat is discarded.
        drive(1'b1, mk('hEE, 5'd6), 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, mk('hDD, 5'd9), 1'b1, 1'b1, 1'b0);
        tick();
        check("flush_one_valid", 96'(ex_valid), 96'(0));
        drive(1'b0, idle, 1'b1, 1'b0, 1'b0);
        tick();
        check("flush_no_ghost", 96'(ex_beat), 96'(0));

        // Bubble: after X retires, payload returns to the NOP encoding.
        drive(1'b1, mk('h77, 5'd7), 1'b1, 1'b0, 1'b0);
        tick();
        check("bubble_x_we", 96'(ex_we), 96'(1));
        check("bubble_x_wa", 96'(ex_wa), 96'(7));
        drive(1'b0, idle, 1'b1, 1'b0, 1'b0);
        tick();
        check("bubble_we", 96'(ex_we), 96'(0));
        check("bubble_wa", 96'(ex_wa), 96'(0));
        check("bubble_t", 96'(ex_t), 96'(0));
        check("bubble_all", 96'(ex_beat), 96'(0));

        // Saturation, then clear while stalled, then simultaneous flush+clear.
        drive(1'b1, mk('h55, 5'd2), 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, idle, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt", 96'(stall_cnt), 96'(CNT_MAX));
        drive(1'b0, idle, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr_cnt", 96'(stall_cnt), 96'(0));
        drive(1'b0, idle, 1'b0, 1'b0, 1'b0);
        tick();
        check("clr_then_inc", 96'(stall_cnt), 96'(1));
        drive(1'b0, idle, 1'b0, 1'b1, 1'b1);
        tick();
        check("flush_clr_cnt", 96'(stall_cnt), 96'(0));
        check("flush_clr_valid", 96'(ex_valid), 96'(0));

        // Asynchronous reset asserted mid-cycle while in TWO.
        drive(1'b1, mk('hA1, 5'd1), 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, mk('hA2, 5'd2), 1'b0, 1'b0, 1'b0);
        tick();
        check("pre_rst_cnt", 96'(stall_cnt), 96'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_valid", 96'(ex_valid), 96'(0));
        check("arst_payload", 96'(ex_beat), 96'(0));
        check("arst_id_ready", 96'(id_ready), 96'(1));
        check("arst_cnt", 96'(stall_cnt), 96'(0));
        drive(1'b0, idle, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_idle", 96'(ex_valid), 96'(0));
        drive(1'b1, mk('hF0, 5'd8), 1'b1, 1'b0, 1'b0);
        tick();
        check("post_rst_first", 96'(ex_beat), 96'(mk('hF0, 5'd8)));
        drive(1'b0, idle, 1'b1, 1'b0, 1'b1);
        tick();

        // Random traffic against an in-order queue model.
        model_q.delete();
        model_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit    v, exr, fl, clr, acc, ret;
            beat_t b, exp_b;
            v   = ($urandom_range(0, 9) < 7);
            exr = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 24) == 0);
            b   = rnd_beat();
            drive(v, b, exr, fl, clr);

            acc = v && (model_q.size() < 2);
            ret = exr && (model_q.size() > 0);
            if (clr) model_cnt = 0;
            else if (model_q.size() > 0 && !exr && model_cnt < CNT_MAX) model_cnt++;
            if (fl) model_q.delete();
            else begin
                if (ret) void'(model_q.pop_front());
                if (acc) model_q.push_back(b);
            end

            tick();
            exp_b = (model_q.size() > 0) ? model_q[0] : '0;
            check("rnd_ex_valid", 96'(ex_valid), 96'(model_q.size() > 0));
            check("rnd_payload", 96'(ex_beat), 96'(exp_b));
            check("rnd_id_ready", 96'(id_ready), 96'(model_q.size() < 2));
            check("rnd_cnt", 96'(stall_cnt), 96'(model_cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
